// File: rtl/cache_tag_lookup_if.sv
// Request, response and replacement-policy signal bundle for cache_tag_lookup.
// master = requester/policy side, slave = the tag lookup block.
interface cache_tag_lookup_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned WAY_COUNT  = 2,
   parameter int unsigned SET_COUNT  = 64,
   parameter int unsigned LINE_BYTES = 16
);
   localparam int unsigned WB = $clog2(WAY_COUNT);
   localparam int unsigned SB = $clog2(SET_COUNT);
   localparam int unsigned OB = $clog2(LINE_BYTES);
   localparam int unsigned TW = ADDR_WIDTH - SB - OB;

   logic                  req_valid;
   logic                  req_ready;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_write;

   logic                  resp_valid;
   logic                  resp_hit;
   logic [WB-1:0]         resp_way;
   logic [SB-1:0]         resp_set;
   logic                  evict_valid;
   logic [TW-1:0]         evict_tag;

   logic [SB-1:0]         rp_set;
   logic [WB-1:0]         rp_way;
   logic [WB-1:0]         rp_replacement_way;
   logic                  rp_ready;
   logic                  rp_read;
   logic                  rp_written;
   logic                  rp_taken;

   modport master (
      output req_valid, req_addr, req_write, rp_replacement_way, rp_ready,
      input  req_ready, resp_valid, resp_hit, resp_way, resp_set, evict_valid, evict_tag,
      input  rp_set, rp_way, rp_read, rp_written, rp_taken
   );

   modport slave (
      input  req_valid, req_addr, req_write, rp_replacement_way, rp_ready,
      output req_ready, resp_valid, resp_hit, resp_way, resp_set, evict_valid, evict_tag,
      output rp_set, rp_way, rp_read, rp_written, rp_taken
   );
endinterface

// File: rtl/cache_tag_lookup.sv
// Tag store and lookup FSM of a set-associative cache, feeding replacement_policy.
// Optional feature macro: CACHE_TAG_FLUSH_EN adds flush/flush_busy and a FLUSH state.
module cache_tag_lookup #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned WAY_COUNT  = 2,
   parameter int unsigned SET_COUNT  = 64,
   parameter int unsigned LINE_BYTES = 16
) (
   input  logic clk,
   input  logic reset,
`ifdef CACHE_TAG_FLUSH_EN
   input  logic flush,
   output logic flush_busy,
`endif
   cache_tag_lookup_if.slave bus
);
   localparam int unsigned WB = $clog2(WAY_COUNT);
   localparam int unsigned SB = $clog2(SET_COUNT);
   localparam int unsigned OB = $clog2(LINE_BYTES);
   localparam int unsigned TW = ADDR_WIDTH - SB - OB;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_UPDATE = 3'd2,
      ST_VICTIM = 3'd3,
      ST_RESP   = 3'd4
`ifdef CACHE_TAG_FLUSH_EN
      , ST_FLUSH = 3'd5
`endif
   } state_t;

   state_t        state_q, state_d;

   logic [TW-1:0] tag_q, tag_d;
   logic [SB-1:0] set_q, set_d;
   logic          write_q, write_d;
   logic          hit_q, hit_d;
   logic          fill_q, fill_d;
   logic [WB-1:0] way_q, way_d;

   logic          req_ready_q, req_ready_d;
   logic          resp_valid_q, resp_valid_d;
   logic          resp_hit_q, resp_hit_d;
   logic [WB-1:0] resp_way_q, resp_way_d;
   logic [SB-1:0] resp_set_q, resp_set_d;
   logic          evict_valid_q, evict_valid_d;
   logic [TW-1:0] evict_tag_q, evict_tag_d;

   logic [TW-1:0] tag_mem_q [SET_COUNT][WAY_COUNT];
   logic          valid_q   [SET_COUNT][WAY_COUNT];

   logic          mem_we_c;
   logic [WB-1:0] mem_way_c;
   logic          rp_read_c, rp_written_c, rp_taken_c;
   logic [WB-1:0] rp_way_c;

   logic          hit_any_c, inv_any_c;
   logic [WB-1:0] hit_way_c, inv_way_c;

   // Line-offset bits never participate in the lookup.
   logic          addr_unused_c;
   assign addr_unused_c = ^bus.req_addr[OB-1:0];

`ifdef CACHE_TAG_FLUSH_EN
   logic [SB-1:0] flush_set_q, flush_set_d;
   logic          flush_busy_q, flush_busy_d;
   logic          flush_clr_c;
`endif

   // Parallel tag compare; descending scan leaves the lowest matching/invalid way.
   always_comb begin
      hit_any_c = 1'b0;
      hit_way_c = '0;
      inv_any_c = 1'b0;
      inv_way_c = '0;
      for (int w = int'(WAY_COUNT) - 1; w >= 0; w--) begin
         if (valid_q[set_q][w] && (tag_mem_q[set_q][w] == tag_q)) begin
            hit_any_c = 1'b1;
            hit_way_c = WB'(w);
         end
         if (!valid_q[set_q][w]) begin
            inv_any_c = 1'b1;
            inv_way_c = WB'(w);
         end
      end
   end

   // Next-state, datapath and policy pulse decode.
   always_comb begin
      state_d       = state_q;
      tag_d         = tag_q;
      set_d         = set_q;
      write_d       = write_q;
      hit_d         = hit_q;
      fill_d        = fill_q;
      way_d         = way_q;
      resp_hit_d    = resp_hit_q;
      resp_way_d    = resp_way_q;
      resp_set_d    = resp_set_q;
      evict_valid_d = evict_valid_q;
      evict_tag_d   = evict_tag_q;
      mem_we_c      = 1'b0;
      mem_way_c     = way_q;
      rp_read_c     = 1'b0;
      rp_written_c  = 1'b0;
      rp_taken_c    = 1'b0;
      rp_way_c      = way_q;
`ifdef CACHE_TAG_FLUSH_EN
      flush_set_d   = flush_set_q;
      flush_clr_c   = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
`ifdef CACHE_TAG_FLUSH_EN
            if (flush) begin
               flush_set_d = '0;
               state_d     = ST_FLUSH;
            end else
`endif
            if (bus.req_valid) begin
               tag_d   = bus.req_addr[ADDR_WIDTH-1 -: TW];
               set_d   = bus.req_addr[OB +: SB];
               write_d = bus.req_write;
               state_d = ST_LOOKUP;
            end
         end

         ST_LOOKUP: begin
            if (hit_any_c) begin
               hit_d   = 1'b1;
               fill_d  = 1'b0;
               way_d   = hit_way_c;
               state_d = ST_UPDATE;
            end else if (inv_any_c) begin
               hit_d   = 1'b0;
               fill_d  = 1'b1;
               way_d   = inv_way_c;
               state_d = ST_UPDATE;
            end else begin
               hit_d   = 1'b0;
               fill_d  = 1'b0;
               state_d = ST_VICTIM;
            end
         end

         ST_UPDATE: begin
            if (bus.rp_ready) begin
               // A load hit is the only read; stores and fills both count as writes.
               rp_read_c     = hit_q && !write_q;
               rp_written_c  = !(hit_q && !write_q);
               mem_we_c      = fill_q;
               mem_way_c     = way_q;
               resp_hit_d    = hit_q;
               resp_way_d    = way_q;
               resp_set_d    = set_q;
               evict_valid_d = 1'b0;
               evict_tag_d   = '0;
               state_d       = ST_RESP;
            end
         end

         ST_VICTIM: begin
            rp_way_c = bus.rp_replacement_way;
            if (bus.rp_ready) begin
               rp_taken_c    = 1'b1;
               mem_we_c      = 1'b1;
               mem_way_c     = bus.rp_replacement_way;
               resp_hit_d    = 1'b0;
               resp_way_d    = bus.rp_replacement_way;
               resp_set_d    = set_q;
               evict_valid_d = 1'b1;
               evict_tag_d   = tag_mem_q[set_q][bus.rp_replacement_way];
               state_d       = ST_RESP;
            end
         end

         ST_RESP: state_d = ST_IDLE;

`ifdef CACHE_TAG_FLUSH_EN
         ST_FLUSH: begin
            flush_clr_c = 1'b1;
            flush_set_d = flush_set_q + SB'(1);
            if (flush_set_q == SB'(SET_COUNT - 1)) begin
               state_d = ST_IDLE;
            end
         end
`endif

         default: state_d = ST_IDLE;
      endcase

      req_ready_d  = (state_d == ST_IDLE);
      resp_valid_d = (state_d == ST_RESP);
`ifdef CACHE_TAG_FLUSH_EN
      flush_busy_d = (state_d == ST_FLUSH);
`endif
   end

   // State, captured request, response registers and tag/valid storage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         tag_q         <= '0;
         set_q         <= '0;
         write_q       <= 1'b0;
         hit_q         <= 1'b0;
         fill_q        <= 1'b0;
         way_q         <= '0;
         req_ready_q   <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_hit_q    <= 1'b0;
         resp_way_q    <= '0;
         resp_set_q    <= '0;
         evict_valid_q <= 1'b0;
         evict_tag_q   <= '0;
`ifdef CACHE_TAG_FLUSH_EN
         flush_set_q   <= '0;
         flush_busy_q  <= 1'b0;
`endif
         for (int s = 0; s < int'(SET_COUNT); s++) begin
            for (int w = 0; w < int'(WAY_COUNT); w++) begin
               tag_mem_q[s][w] <= '0;
               valid_q[s][w]   <= 1'b0;
            end
         end
      end else begin
         state_q       <= state_d;
         tag_q         <= tag_d;
         set_q         <= set_d;
         write_q       <= write_d;
         hit_q         <= hit_d;
         fill_q        <= fill_d;
         way_q         <= way_d;
         req_ready_q   <= req_ready_d;
         resp_valid_q  <= resp_valid_d;
         resp_hit_q    <= resp_hit_d;
         resp_way_q    <= resp_way_d;
         resp_set_q    <= resp_set_d;
         evict_valid_q <= evict_valid_d;
         evict_tag_q   <= evict_tag_d;
         if (mem_we_c) begin
            tag_mem_q[set_q][mem_way_c] <= tag_q;
            valid_q[set_q][mem_way_c]   <= 1'b1;
         end
`ifdef CACHE_TAG_FLUSH_EN
         flush_set_q  <= flush_set_d;
         flush_busy_q <= flush_busy_d;
         if (flush_clr_c) begin
            for (int w = 0; w < int'(WAY_COUNT); w++) begin
               valid_q[flush_set_q][w] <= 1'b0;
            end
         end
`endif
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.resp_valid  = resp_valid_q;
   assign bus.resp_hit    = resp_hit_q;
   assign bus.resp_way    = resp_way_q;
   assign bus.resp_set    = resp_set_q;
   assign bus.evict_valid = evict_valid_q;
   assign bus.evict_tag   = evict_tag_q;
   assign bus.rp_set      = set_q;
   assign bus.rp_way      = rp_way_c;
   assign bus.rp_read     = rp_read_c;
   assign bus.rp_written  = rp_written_c;
   assign bus.rp_taken    = rp_taken_c;
`ifdef CACHE_TAG_FLUSH_EN
   assign flush_busy      = flush_busy_q;
`endif
endmodule

// File: tb/tb_cache_tag_lookup.sv
// Directed bench for cache_tag_lookup: hit/miss/fill/evict sequences, stalls, reset abort.
module tb_cache_tag_lookup;
   localparam int unsigned AW = 32;
   localparam int unsigned WC = 2;
   localparam int unsigned SC = 64;
   localparam int unsigned LB = 16;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cache_tag_lookup_if #(.ADDR_WIDTH(AW), .WAY_COUNT(WC), .SET_COUNT(SC), .LINE_BYTES(LB)) bus ();

`ifdef CACHE_TAG_FLUSH_EN
   logic flush;
   logic flush_busy;
`endif

   cache_tag_lookup #(.ADDR_WIDTH(AW), .WAY_COUNT(WC), .SET_COUNT(SC), .LINE_BYTES(LB)) dut (
      .clk        (clk),
      .reset      (reset),
`ifdef CACHE_TAG_FLUSH_EN
      .flush      (flush),
      .flush_busy (flush_busy),
`endif
      .bus        (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Observations of the last request
   int          lat, n_rd, n_wr, n_tk, n_low, n_dbl;
   logic        p_way;
   logic [5:0]  p_set;
   logic        r_hit, r_ev, r_way;
   logic [5:0]  r_set;
   logic [21:0] r_tag;

   task automatic do_req(input logic [31:0] addr, input logic wr, input logic vic, input int stall);
      lat = -1; n_rd = 0; n_wr = 0; n_tk = 0; n_low = 0; n_dbl = 0;
      p_way = 1'b0; p_set = '0; r_hit = 1'b0; r_ev = 1'b0; r_way = 1'b0; r_set = '0; r_tag = '0;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = addr;
      bus.req_write = wr;
      bus.rp_replacement_way = vic;
      bus.rp_ready  = 1'b1;
      @(posedge clk);
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         bus.req_valid = 1'b0;
         bus.rp_ready  = !(c >= 2 && c < 2 + stall);
         #1;
         if (bus.rp_read || bus.rp_written || bus.rp_taken) begin
            n_rd += int'(bus.rp_read);
            n_wr += int'(bus.rp_written);
            n_tk += int'(bus.rp_taken);
            p_way = bus.rp_way;
            p_set = bus.rp_set;
            if (!bus.rp_ready) n_low++;
            if (int'(bus.rp_read) + int'(bus.rp_written) + int'(bus.rp_taken) > 1) n_dbl++;
         end
         if (bus.resp_valid) begin
            lat   = c;
            r_hit = bus.resp_hit;
            r_way = bus.resp_way;
            r_set = bus.resp_set;
            r_ev  = bus.evict_valid;
            r_tag = bus.evict_tag;
            break;
         end
      end
      bus.rp_ready = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int resp_cnt;
      reset = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_addr  = '0;
      bus.req_write = 1'b0;
      bus.rp_replacement_way = 1'b0;
      bus.rp_ready  = 1'b1;
`ifdef CACHE_TAG_FLUSH_EN
      flush = 1'b0;
`endif
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_pulses", {bus.rp_read, bus.rp_written, bus.rp_taken}, 0);
      check("rst_evict_valid", bus.evict_valid, 0);
      check("rst_rp_set", bus.rp_set, 0);
      check("rst_resp_way", bus.resp_way, 0);

      // Cold miss into set 4: fill way 0
      do_req(32'h40, 1'b0, 1'b0, 0);
      check("t1_latency", lat, 3);
      check("t1_hit", r_hit, 0);
      check("t1_way", r_way, 0);
      check("t1_set", r_set, 4);
      check("t1_evict_valid", r_ev, 0);
      check("t1_written", n_wr, 1);
      check("t1_read", n_rd, 0);
      check("t1_taken", n_tk, 0);
      check("t1_rp_way", p_way, 0);
      check("t1_rp_set", p_set, 4);
      @(negedge clk); #1;
      check("t1_resp_one_cycle", bus.resp_valid, 0);

      // Load hit same line
      do_req(32'h44, 1'b0, 1'b0, 0);
      check("t2_latency", lat, 3);
      check("t2_hit", r_hit, 1);
      check("t2_way", r_way, 0);
      check("t2_set", r_set, 4);
      check("t2_read", n_rd, 1);
      check("t2_written", n_wr, 0);
      check("t2_rp_way", p_way, 0);

      // Store miss, tag 1: fills invalid way 1
      do_req(32'h440, 1'b1, 1'b0, 0);
      check("t3_hit", r_hit, 0);
      check("t3_way", r_way, 1);
      check("t3_written", n_wr, 1);
      check("t3_rp_way", p_way, 1);
      check("t3_evict_valid", r_ev, 0);

      // Set full: tag 2 evicts way 0 (tag 0)
      do_req(32'h840, 1'b0, 1'b0, 0);
      check("t4_latency", lat, 3);
      check("t4_taken", n_tk, 1);
      check("t4_rp_way", p_way, 0);
      check("t4_way", r_way, 0);
      check("t4_hit", r_hit, 0);
      check("t4_evict_valid", r_ev, 1);
      check("t4_evict_tag", r_tag, 0);
      check("t4_pulse_total", n_rd + n_wr + n_tk, 1);

      // Tag 0 was evicted: misses again, victim way 1 holds tag 1
      do_req(32'h40, 1'b0, 1'b1, 0);
      check("t4b_hit", r_hit, 0);
      check("t4b_way", r_way, 1);
      check("t4b_evict_valid", r_ev, 1);
      check("t4b_evict_tag", r_tag, 1);
      check("t4b_taken", n_tk, 1);

      // Hit on tag 2 (way 0) with policy stalled 5 cycles
      do_req(32'h840, 1'b0, 1'b0, 5);
      check("t5_latency", lat, 8);
      check("t5_hit", r_hit, 1);
      check("t5_way", r_way, 0);
      check("t5_pulse_while_low", n_low, 0);
      check("t5_read", n_rd, 1);
      check("t5_double_pulse", n_dbl, 0);

      // Store hit reports a write pulse
      do_req(32'h844, 1'b1, 1'b0, 0);
      check("t5s_hit", r_hit, 1);
      check("t5s_written", n_wr, 1);
      check("t5s_read", n_rd, 0);

      // Top set and widest tag
      do_req(32'h3F0, 1'b0, 1'b0, 0);
      check("t7_set", r_set, 63);
      check("t7_way", r_way, 0);
      check("t7_hit", r_hit, 0);
      do_req(32'hFFFF_FFF0, 1'b0, 1'b0, 0);
      check("t7b_way", r_way, 1);
      check("t7b_evict_valid", r_ev, 0);
      do_req(32'hFFFF_FFF8, 1'b0, 1'b0, 0);
      check("t7c_hit", r_hit, 1);
      check("t7c_way", r_way, 1);
      do_req(32'h17F0, 1'b0, 1'b1, 0);
      check("t7d_evict_tag", r_tag, 22'h3F_FFFF);
      check("t7d_way", r_way, 1);
      check("t7d_rp_set", p_set, 63);

      // Reset while stalled in UPDATE aborts the request
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h40;
      bus.req_write = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.rp_ready  = 1'b0;
      @(negedge clk);
      #1;
      reset = 1'b1;
      #2;
      reset = 1'b0;
      #1;
      check("t6_req_ready", bus.req_ready, 1);
      check("t6_pulses", {bus.rp_read, bus.rp_written, bus.rp_taken}, 0);
      bus.rp_ready = 1'b1;
      resp_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); #1;
         resp_cnt += int'(bus.resp_valid);
      end
      check("t6_no_resp", resp_cnt, 0);
      do_req(32'h440, 1'b0, 1'b0, 0);
      check("t6_hit", r_hit, 0);
      check("t6_way", r_way, 0);
      check("t6_evict_valid", r_ev, 0);

`ifdef CACHE_TAG_FLUSH_EN
      begin
         int busy_cnt, rdy_bad, pulse_cnt;
         do_req(32'h840, 1'b0, 1'b0, 0);
         check("f_prefill_way", r_way, 1);
         @(negedge clk);
         flush = 1'b1;
         @(posedge clk);
         @(negedge clk);
         flush = 1'b0;
         busy_cnt = 0; rdy_bad = 0; pulse_cnt = 0;
         for (int i = 0; i < 200; i++) begin
            #1;
            if (!flush_busy) break;
            busy_cnt++;
            if (bus.req_ready) rdy_bad++;
            if (bus.rp_read || bus.rp_written || bus.rp_taken) pulse_cnt++;
            @(negedge clk);
         end
         check("f_busy_cycles", busy_cnt, 64);
         check("f_ready_during_flush", rdy_bad, 0);
         check("f_pulses", pulse_cnt, 0);
         do_req(32'h440, 1'b0, 1'b0, 0);
         check("f_hit", r_hit, 0);
         check("f_way", r_way, 0);
         check("f_evict_valid", r_ev, 0);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
